// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: NOP word, FSM encoding, reset vector,
// fault cause codes and the payload presented to the decoder.
package instr_fetch_pkg;

  localparam int unsigned XLEN_W  = 32;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_REQ  = 2'd0;
  localparam logic [STATE_W-1:0] S_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] S_HOLD = 2'd2;

  localparam logic [XLEN_W-1:0] FETCH_NOP          = 32'h0000_0013;
  localparam logic [XLEN_W-1:0] FETCH_RESET_VECTOR = 32'h0000_0000;

  // Cause codes handed to the trap unit alongside instr_fault
  typedef enum logic [3:0] {
    FETCH_FAULT_MISALIGN = 4'd0,
    FETCH_FAULT_ACCESS   = 4'd1
  } fetch_fault_e;

  typedef struct packed {
    logic [XLEN_W-1:0] instr;
    logic [XLEN_W-1:0] pc;
    logic              fault;
  } fetch_out_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// PC register with +4 advance, redirect muxing and alignment check for instr_fetch.
// FETCH_MISALIGN_CHECK_EN: flag redirect targets whose low two bits are non-zero.
module fetch_pc_gen
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN_W-1:0] RESET_VECTOR = FETCH_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              redirect_valid,
  input  logic [XLEN_W-1:0] redirect_pc,
  output logic [XLEN_W-1:0] pc,
  output logic              misalign_c
);

  localparam int unsigned WORD_W = XLEN_W - 2;

  // Only the word index is stored, so the fetch address is aligned by construction
  logic [WORD_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc[XLEN_W-1:2];
    end else if (advance) begin
      pc_d = pc_q + WORD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR[XLEN_W-1:2];
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = {pc_q, 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_c = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign misalign_c = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding word request, registered handoff to the decoder,
// redirects discard in-flight responses. Misaligned-target faulting via FETCH_MISALIGN_CHECK_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = FETCH_RESET_VECTOR,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            instr_fault
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               drop_q, drop_d;
  logic               valid_q, valid_d;
  fetch_out_t         out_q, out_d;
  logic [XLEN_W-1:0]  pc;
  logic               advance_c;
  logic               misalign_c;
  logic               rsp_owed;

  fetch_pc_gen #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .advance       (advance_c),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .misalign_c    (misalign_c)
  );

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    out_d     = out_q;
    advance_c = 1'b0;

    case (state_q)
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_d     = '{instr: imem_rsp_data, pc: pc, fault: imem_rsp_err};
            valid_d   = 1'b1;
            advance_c = 1'b1;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A fault raised on a redirect may still owe a stale response
        if (drop_q && imem_rsp_valid) drop_d = 1'b0;
        if (instr_ready) begin
          valid_d = 1'b0;
          state_d = drop_d ? S_WAIT : S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    rsp_owed = (state_d == S_WAIT) || drop_d;

    if (redirect_valid) begin
      out_d     = out_q;
      valid_d   = 1'b0;
      advance_c = 1'b0;
      drop_d    = rsp_owed;
      state_d   = rsp_owed ? S_WAIT : S_REQ;
      if (misalign_c) begin
        out_d   = '{instr: FETCH_NOP, pc: redirect_pc, fault: 1'b1};
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '{instr: FETCH_NOP, pc: '0, fault: 1'b0};
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc;
  assign instr          = out_q.instr;
  assign instr_pc       = out_q.pc;
  assign instr_fault    = out_q.fault;
  assign instr_valid    = valid_q;

`ifndef SYNTHESIS
  rsp_only_when_owed_a: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (state_q == S_WAIT || drop_q));
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage that sits directly upstream of instr_decoder. It owns the PC and issues one word request at a time to instruction memory. It registers each returned word and presents it, with its PC, to the decoder over a valid/ready handshake. Redirects from execute (branch/jump/trap target) restart fetch and discard any in-flight response.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
XLEN, 32, address/data width (only 32 supported)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  request to instruction memory
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response data valid
imem_rsp_data  input  32  instruction word
imem_rsp_err  input  1  bus error on this response
redirect_valid  input  1  load new PC (one-cycle pulse)
redirect_pc  input  32  target PC
instr  output  32  instruction to decoder
instr_pc  output  32  PC of instr
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decoder accepts
instr_fault  output  1  fetch fault, qualified by instr_valid

Behaviour:
- Reset (async): state=S_REQ, pc=RESET_VECTOR, drop=0, instr=32'h0000_0013 (NOP), instr_pc=0, instr_valid=0, instr_fault=0. imem_req_valid is combinational from state, so it is 1 as soon as rst deasserts.
- Single outstanding request. FSM:
  - S_REQ: imem_req_valid=1, imem_req_addr={pc[31:2],2'b00}. On imem_req_ready, go to S_WAIT.
  - S_WAIT: wait for imem_rsp_valid. On a response with drop=0:
    - capture instr=imem_rsp_data, instr_pc=pc, instr_fault=imem_rsp_err, instr_valid=1, pc=pc+4 (wraps mod 2^32);
    - go to S_HOLD.
  - On a response with drop=1: discard it, clear drop, go to S_REQ.
  - S_HOLD: instr_valid=1. On instr_ready, clear instr_valid and go to S_REQ.
- Outputs are stable while instr_valid=1 and instr_ready=0.
- On error, instr is still the captured data. The decoder path treats instr_fault as the exception source.
- Latency: with zero-wait memory (ready=1, response the cycle after accept), instr_valid rises 2 cycles after imem_req_valid. Throughput is 1 instr per 3 cycles.
- Redirect (highest priority, any state):
  - pc=redirect_pc, instr_valid=0 next cycle, state=S_REQ.
  - If redirect arrives in S_WAIT, or in S_REQ in the same cycle as a request accept, set drop=1 and go to S_WAIT so the stale response is consumed and discarded.
  - Redirect in the same cycle as an instr handshake: the handshake counts as completed, and the redirect still applies.
  - Redirect in the same cycle as a non-dropped response: the response is discarded and the redirect applies.
  - Back-to-back redirects: the last one wins; drop stays 1 until one response has been absorbed.
- imem_req_addr low bits are always 00. Without the optional feature, redirect_pc[1:0] is forced to 0.
- imem_rsp_valid outside S_WAIT is ignored (protocol violation; an assertion flags it in simulation).

Optional Feature:
FETCH_MISALIGN_CHECK_EN.
- Defined: redirect_pc[1:0]!=0 issues no memory request. Next cycle: instr=NOP, instr_pc=redirect_pc, instr_fault=1, instr_valid=1, state=S_HOLD. Any pending drop is still honoured.
- Undefined: low bits are silently cleared and fetch proceeds from the aligned address.

Decomposition:
- Shared header (alongside instruction_type.vh) holds:
  - FETCH_NOP (32'h0000_0013);
  - the S_REQ/S_WAIT/S_HOLD state encoding and width;
  - RESET_VECTOR default;
  - FETCH_FAULT cause codes for the trap unit.
- One sub-module: fetch_pc_gen. It holds the PC register, the +4 increment, redirect muxing and the alignment check. The FSM and output register stay in instr_fetch.

Test Plan:
- Reset release, ready=1, memory returns 32'h00500093 one cycle after accept, instr_ready=1 -> imem_req_addr=0x0; instr=0x00500093, instr_pc=0x0 valid on cycle 2; next req addr=0x4.
- instr_ready=0 for 5 cycles after instr_valid -> instr/instr_pc held; no new imem request until the handshake.
- Redirect to 0x100 while in S_WAIT; stale response 0xDEADBEEF arrives next cycle -> 0xDEADBEEF never reaches instr_valid; next req addr=0x100; delivered instr_pc=0x100.
- imem_rsp_err=1 with data 0x0 at PC 0x8 -> instr_valid=1, instr_fault=1, instr_pc=0x8; next fetch 0xC.
- PC 0xFFFF_FFFC fetched -> next req addr wraps to 0x0000_0000.
- Redirect to 0x102, with and without FETCH_MISALIGN_CHECK_EN:
  - with: fault with instr_pc=0x102 and no request;
  - without: req addr=0x100.
